id_hazard_ctrl: RTL and testbench
=================================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have if_valid  input  1  IF presents an instruction.
REQ-005 SHALL have if_instr  input  32  instruction from IF.
REQ-006 SHALL have id_ready  output  1  ID accepts if_instr this cycle (also PC advance enable).
REQ-007 SHALL have id_valid  output  1  ID register holds a live instruction.
REQ-008 SHALL have id_instr  output  32  registered ID instruction (bits [31:7] feed immgen).
REQ-009 SHALL have imm_sel  output  immgen_t  immediate format for id_instr.
REQ-010 SHALL have illegal_instr  output  1  id_valid and opcode unrecognised.
REQ-011 SHALL have ex_valid  output  1  ID issues id_instr to EX this cycle (0 = bubble).
REQ-012 SHALL have ex_ready  input  1  EX accepts an issue this cycle.
REQ-013 SHALL have ex_is_load  input  1  instruction currently in EX is a load.
REQ-014 SHALL have ex_rd  input  5  destination register of the EX instruction.
REQ-015 SHALL have branch_taken  input  1  EX redirect; flush younger instructions.
REQ-016 SHALL have stall_cycles  output  CNT_W  saturating count of ID stall cycles.

Function
REQ-017 SHALL decode id_instr[6:0] combinationally: 0000011/0010011/1100111 -> IMMGEN_I; 0100011 -> IMMGEN_S; 1100011 -> IMMGEN_SB; 1101111 -> IMMGEN_UJ; 0110111/0010111 -> IMMGEN_U; 0110011 -> IMMGEN_I (unused); any other -> IMMGEN_I with illegal_instr = id_valid.
REQ-018 SHALL treat rs1 (id_instr[19:15]) as used for all recognised opcodes except JAL, LUI, AUIPC; rs2 (id_instr[24:20]) as used only for 0110011, 0100011, 1100011.
REQ-019 SHALL define load_use = id_valid & ex_is_load & (ex_rd != 0) & ((rs1 used & rs1 == ex_rd) | (rs2 used & rs2 == ex_rd)).
REQ-020 SHALL implement FSM states RUN, LOAD_STALL, FLUSH; reset state RUN.
REQ-021 Priority each cycle SHALL be: reset > branch_taken > state action.
REQ-022 On branch_taken (any state): ex_valid = 0, id_ready = 1, next id_valid = 0, next state FLUSH.
REQ-023 FLUSH: ex_valid = 0, id_ready = 1, if_instr discarded (id_valid stays 0), next state RUN unconditionally.
REQ-024 RUN with load_use: ex_valid = 0, id_ready = 0, id_instr held, next state LOAD_STALL.
REQ-025 RUN without load_use: ex_valid = id_valid; id_ready = !id_valid | ex_ready.
REQ-026 LOAD_STALL: load_use ignored; ex_valid = id_valid; id_ready = !id_valid | ex_ready; next state RUN when id_ready, else stay.
REQ-027 When id_ready & if_valid outside FLUSH/branch_taken: id_instr <= if_instr, id_valid <= 1; when id_ready & !if_valid: id_valid <= 0; when !id_ready: hold.
REQ-028 Exactly one bubble SHALL be inserted per load-use hazard (ex_ready = 1 case).
REQ-029 stall_cycles SHALL increment when id_valid & !id_ready & !branch_taken, saturating at 2^CNT_W-1 (no wrap).
REQ-030 All outputs except registered state SHALL be combinational from state, id_instr and inputs; no combinational path from if_instr to any output.

Reset
REQ-031 With rst_n = 0 at a clk edge: state RUN, id_valid 0, id_instr 0, stall_cycles 0; ex_valid 0, id_ready 1, illegal_instr 0 follow combinationally.
REQ-032 Reset asserted mid-LOAD_STALL or mid-FLUSH SHALL return to RUN with REQ-031 values on the next edge, overriding branch_taken.

Verification
REQ-033 Load 0x00002083 (lw x1) in EX (ex_is_load=1, ex_rd=1), ID holds 0x00108133 (add x2,x1,x1) -> one cycle ex_valid=0, id_ready=0, then ex_valid=1 with same id_instr; stall_cycles +1.
REQ-034 ex_rd=0, ex_is_load=1, ID reads x0 -> no stall, ex_valid=1 immediately.
REQ-035 branch_taken=1 while ID valid -> next cycle id_valid=0, state FLUSH, incoming if_instr dropped; following cycle normal acceptance resumes.
REQ-036 branch_taken coincident with load_use -> flush wins: ex_valid=0, no LOAD_STALL entered, stall_cycles unchanged.
REQ-037 Opcodes 0100011, 1100011, 1101111, 0110111, 0000000 -> imm_sel S, SB, UJ, U, I with illegal_instr=1 only for 0000000.
REQ-038 CNT_W=4, hold ex_ready=0 for 20 cycles with ID valid -> stall_cycles saturates at 15; rst_n=0 -> 0.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID stage register with immediate decode, load-use stall and branch flush control
package id_hazard_pkg;
    typedef enum logic [2:0] {
        IMMGEN_I  = 3'd0,
        IMMGEN_S  = 3'd1,
        IMMGEN_SB = 3'd2,
        IMMGEN_UJ = 3'd3,
        IMMGEN_U  = 3'd4
    } immgen_t;
endpackage

module id_hazard_ctrl
    import id_hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    output logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_instr,
    output immgen_t          imm_sel,
    output logic             illegal_instr,
    output logic             ex_valid,
    input  logic             ex_ready,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t state, state_d;

    logic       known_op;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;
    logic       drop_fetch;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];

    always_comb begin
        imm_sel  = IMMGEN_I;
        known_op = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (id_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: imm_sel = IMMGEN_I;
            7'b0100011: begin
                imm_sel  = IMMGEN_S;
                rs2_used = 1'b1;
            end
            7'b1100011: begin
                imm_sel  = IMMGEN_SB;
                rs2_used = 1'b1;
            end
            7'b1101111: begin
                imm_sel  = IMMGEN_UJ;
                rs1_used = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                imm_sel  = IMMGEN_U;
                rs1_used = 1'b0;
            end
            7'b0110011: rs2_used = 1'b1;
            default: begin
                known_op = 1'b0;
                rs1_used = 1'b0;
            end
        endcase
    end

    assign illegal_instr = id_valid & ~known_op;

    assign load_use = id_valid & ex_is_load & (ex_rd != 5'd0) &
                      ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));

    always_comb begin
        state_d    = state;
        ex_valid   = 1'b0;
        id_ready   = 1'b1;
        drop_fetch = 1'b0;
        if (branch_taken) begin
            state_d    = FLUSH;
            drop_fetch = 1'b1;
        end else begin
            case (state)
                FLUSH: begin
                    state_d    = RUN;
                    drop_fetch = 1'b1;
                end
                LOAD_STALL: begin
                    ex_valid = id_valid;
                    id_ready = ~id_valid | ex_ready;
                    state_d  = id_ready ? RUN : LOAD_STALL;
                end
                default: begin
                    if (load_use) begin
                        id_ready = 1'b0;
                        state_d  = LOAD_STALL;
                    end else begin
                        ex_valid = id_valid;
                        id_ready = ~id_valid | ex_ready;
                    end
                end
            endcase
        end
    end

    // Flushed cycles clear id_valid but keep id_instr; decode is qualified by id_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            id_valid     <= 1'b0;
            id_instr     <= 32'd0;
            stall_cycles <= '0;
        end else begin
            state <= state_d;
            if (drop_fetch) begin
                id_valid <= 1'b0;
            end else if (id_ready) begin
                id_valid <= if_valid;
                if (if_valid) begin
                    id_instr <= if_instr;
                end
            end
            if (id_valid && !id_ready && !branch_taken && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - scoreboard bench for id_hazard_ctrl with directed hazard/flush/decode vectors
module tb_id_hazard_ctrl;
    import id_hazard_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic          id_ready;
    logic          id_valid;
    logic [31:0]   id_instr;
    immgen_t       imm_sel;
    logic          illegal_instr;
    logic          ex_valid;
    logic          ex_ready;
    logic          ex_is_load;
    logic [4:0]    ex_rd;
    logic          branch_taken;
    logic [CW-1:0] stall_cycles;

    id_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .imm_sel(imm_sel), .illegal_instr(illegal_instr), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          idr;
        logic          exv;
        logic          idv;
        logic [31:0]   instr;
        logic [CW-1:0] stall;
        immgen_t       imm;
        logic          ill;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (id_ready !== e.idr || ex_valid !== e.exv || id_valid !== e.idv ||
                id_instr !== e.instr || stall_cycles !== e.stall ||
                imm_sel !== e.imm || illegal_instr !== e.ill) begin
                errors++;
                $display("FAIL %s: got idr=%b exv=%b idv=%b instr=%h stall=%0d imm=%0d ill=%b, expected idr=%b exv=%b idv=%b instr=%h stall=%0d imm=%0d ill=%b",
                         n, id_ready, ex_valid, id_valid, id_instr, stall_cycles, imm_sel, illegal_instr,
                         e.idr, e.exv, e.idv, e.instr, e.stall, e.imm, e.ill);
            end
        end
    end

    task automatic step(input string n, input logic rst, input logic ifv, input logic [31:0] ifi,
                        input logic exr, input logic exl, input logic [4:0] exrd, input logic br,
                        input logic e_idr, input logic e_exv, input logic e_idv, input logic [31:0] e_instr,
                        input int e_stall, input immgen_t e_imm, input logic e_ill);
        exp_t e;
        rst_n        = rst;
        if_valid     = ifv;
        if_instr     = ifi;
        ex_ready     = exr;
        ex_is_load   = exl;
        ex_rd        = exrd;
        branch_taken = br;
        e.idr   = e_idr;
        e.exv   = e_exv;
        e.idv   = e_idv;
        e.instr = e_instr;
        e.stall = CW'(e_stall);
        e.imm   = e_imm;
        e.ill   = e_ill;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; ex_ready = 1'b1;
        ex_is_load = 1'b0; ex_rd = 5'd0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        //    name          rst ifv ifi           exr exl rd br  idr exv idv instr         st imm        ill
        step("reset",       0, 0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 32'h0,        0, IMMGEN_I,  0);
        step("load_add",    1, 1, 32'h00108133, 1, 0, 0, 0,  1, 0, 0, 32'h0,        0, IMMGEN_I,  0);
        step("lu_stall",    1, 1, 32'h00000013, 1, 1, 1, 0,  0, 0, 1, 32'h00108133, 0, IMMGEN_I,  0);
        step("lu_issue",    1, 1, 32'h00000013, 1, 0, 0, 0,  1, 1, 1, 32'h00108133, 1, IMMGEN_I,  0);
        step("x0_nostall",  1, 1, 32'h00002083, 1, 1, 0, 0,  1, 1, 1, 32'h00000013, 1, IMMGEN_I,  0);
        step("branch",      1, 1, 32'h00208133, 1, 0, 0, 1,  1, 0, 1, 32'h00002083, 1, IMMGEN_I,  0);
        step("flush_drop",  1, 1, 32'h00208133, 1, 0, 0, 0,  1, 0, 0, 32'h00002083, 1, IMMGEN_I,  0);
        step("resume",      1, 1, 32'h00108133, 1, 0, 0, 0,  1, 0, 0, 32'h00002083, 1, IMMGEN_I,  0);
        step("br_vs_lu",    1, 1, 32'h00002023, 1, 1, 1, 1,  1, 0, 1, 32'h00108133, 1, IMMGEN_I,  0);
        step("post_br",     1, 0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 32'h00108133, 1, IMMGEN_I,  0);
        step("load_sw",     1, 1, 32'h00002023, 1, 0, 0, 0,  1, 0, 0, 32'h00108133, 1, IMMGEN_I,  0);
        step("op_s",        1, 1, 32'h00000063, 1, 0, 0, 0,  1, 1, 1, 32'h00002023, 1, IMMGEN_S,  0);
        step("op_sb",       1, 1, 32'h0000006f, 1, 0, 0, 0,  1, 1, 1, 32'h00000063, 1, IMMGEN_SB, 0);
        step("op_uj",       1, 1, 32'h00000037, 1, 0, 0, 0,  1, 1, 1, 32'h0000006f, 1, IMMGEN_UJ, 0);
        step("op_u",        1, 1, 32'h00000000, 1, 0, 0, 0,  1, 1, 1, 32'h00000037, 1, IMMGEN_U,  0);
        step("op_illegal",  1, 1, 32'h00000013, 1, 0, 0, 0,  1, 1, 1, 32'h00000000, 1, IMMGEN_I,  1);
        for (int k = 0; k < 20; k++) begin
            step($sformatf("sat_%0d", k), 1, 1, 32'h00000033, 0, 0, 0, 0,
                 0, 1, 1, 32'h00000013, (k + 1 > 15) ? 15 : k + 1, IMMGEN_I, 0);
        end
        step("sat_hold",    1, 1, 32'h00000033, 0, 0, 0, 0,  0, 1, 1, 32'h00000013, 15, IMMGEN_I, 0);
        step("rst_assert",  0, 1, 32'h00000033, 0, 0, 0, 0,  0, 1, 1, 32'h00000013, 15, IMMGEN_I, 0);
        step("rst_vs_br",   0, 1, 32'h00000033, 1, 0, 0, 1,  1, 0, 0, 32'h0,        0, IMMGEN_I,  0);
        step("rst_release", 1, 1, 32'h00108133, 1, 0, 0, 0,  1, 0, 0, 32'h0,        0, IMMGEN_I,  0);
        step("no_flush",    1, 1, 32'h00108133, 1, 0, 0, 0,  1, 1, 1, 32'h00108133, 0, IMMGEN_I,  0);
        step("lu2_stall",   1, 0, 32'h0,        1, 1, 1, 0,  0, 0, 1, 32'h00108133, 0, IMMGEN_I,  0);
        step("rst_in_ls",   0, 0, 32'h0,        0, 0, 0, 0,  0, 1, 1, 32'h00108133, 1, IMMGEN_I,  0);
        step("after_ls_rst",1, 0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 32'h0,        0, IMMGEN_I,  0);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
